// File: rtl/ternary_threshold_packer.sv
// Thresholds each accepted preactivation to a trit, packs five trits base-3 per byte and
// OUTPUT_WIDTH/8 bytes per word. Define THRESH_PACK_STATS_EN to add per-trit-value counters.
module ternary_threshold_packer #(
    parameter int OUTPUT_WIDTH = 32,
    parameter int PREACT_WIDTH = 32,
    parameter int THRESH_WIDTH = 16
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           in_valid_i,
    output logic                           in_ready_o,
    input  logic signed [PREACT_WIDTH-1:0] preact_i,
    input  logic signed [THRESH_WIDTH-1:0] thresh_lo_i,
    input  logic signed [THRESH_WIDTH-1:0] thresh_hi_i,
    input  logic                           flush_i,
    output logic                           out_valid_o,
    input  logic                           out_ready_i,
    output logic [OUTPUT_WIDTH-1:0]        out_data_o,
    output logic                           out_last_o
`ifdef THRESH_PACK_STATS_EN
    ,
    output logic [15:0]                    stat_pos_o,
    output logic [15:0]                    stat_neg_o,
    output logic [15:0]                    stat_zero_o
`endif
);
    localparam int NB  = OUTPUT_WIDTH / 8;
    localparam int BCW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [BCW-1:0] LAST_BYTE = BCW'(NB - 1);

    logic [2:0]              trit_cnt_q, trit_cnt_d;
    logic [BCW-1:0]          byte_cnt_q, byte_cnt_d;
    logic [7:0]              acc_q, acc_d;
    logic [7:0]              weight_q, weight_d;
    logic [OUTPUT_WIDTH-1:0] word_q, word_d;
    logic                    out_valid_q, out_valid_d;
    logic [OUTPUT_WIDTH-1:0] out_data_q, out_data_d;
    logic                    out_last_q, out_last_d;

    logic signed [PREACT_WIDTH-1:0] lo_ext, hi_ext;
    logic [1:0]  digit;
    logic [7:0]  addend, acc_sum;
    logic        take, do_flush, emit, emit_last;
    logic [OUTPUT_WIDTH-1:0] emit_word, word_full;

    assign lo_ext     = PREACT_WIDTH'(thresh_lo_i);
    assign hi_ext     = PREACT_WIDTH'(thresh_hi_i);
    assign in_ready_o = !out_valid_q || out_ready_i;
    assign take       = in_valid_i && in_ready_o;
    assign do_flush   = flush_i && in_ready_o;

    // Digit encoding: 0 -> 0, +1 -> 1, -1 -> 2; the +1 test wins when lo > hi.
    always_comb begin
        digit = 2'd0;
        if (preact_i > hi_ext) begin
            digit = 2'd1;
        end else if (preact_i < lo_ext) begin
            digit = 2'd2;
        end
    end

    assign addend  = (digit == 2'd1) ? weight_q :
                     (digit == 2'd2) ? {weight_q[6:0], 1'b0} : 8'd0;
    assign acc_sum = acc_q + addend;

    always_comb begin
        trit_cnt_d  = trit_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        acc_d       = acc_q;
        weight_d    = weight_q;
        word_d      = word_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        emit        = 1'b0;
        emit_last   = 1'b0;
        emit_word   = '0;
        word_full   = word_q | (OUTPUT_WIDTH'(acc_sum) << {byte_cnt_q, 3'b000});

        if (take) begin
            if (trit_cnt_q == 3'd4) begin
                acc_d      = 8'd0;
                weight_d   = 8'd1;
                trit_cnt_d = 3'd0;
                if (byte_cnt_q == LAST_BYTE) begin
                    emit       = 1'b1;
                    emit_word  = word_full;
                    emit_last  = do_flush;
                    word_d     = '0;
                    byte_cnt_d = '0;
                end else begin
                    word_d     = word_full;
                    byte_cnt_d = byte_cnt_q + 1'b1;
                end
            end else begin
                acc_d      = acc_sum;
                weight_d   = weight_q + {weight_q[6:0], 1'b0};
                trit_cnt_d = trit_cnt_q + 3'd1;
            end
        end

        // Untouched upper bytes of word are already zero, so OR-ing in the partial byte pads.
        if (do_flush && !emit && (trit_cnt_d != 3'd0 || byte_cnt_d != '0)) begin
            emit       = 1'b1;
            emit_last  = 1'b1;
            emit_word  = word_d | (OUTPUT_WIDTH'(acc_d) << {byte_cnt_d, 3'b000});
            word_d     = '0;
            acc_d      = 8'd0;
            weight_d   = 8'd1;
            trit_cnt_d = 3'd0;
            byte_cnt_d = '0;
        end

        if (emit) begin
            out_valid_d = 1'b1;
            out_data_d  = emit_word;
            out_last_d  = emit_last;
        end else if (out_valid_q && out_ready_i) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            trit_cnt_q  <= 3'd0;
            byte_cnt_q  <= '0;
            acc_q       <= 8'd0;
            weight_q    <= 8'd1;
            word_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            trit_cnt_q  <= trit_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            acc_q       <= acc_d;
            weight_q    <= weight_d;
            word_q      <= word_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_last_o  = out_last_q;

`ifdef THRESH_PACK_STATS_EN
    logic [15:0] pos_q, neg_q, zero_q;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pos_q  <= 16'd0;
            neg_q  <= 16'd0;
            zero_q <= 16'd0;
        end else if (take) begin
            if (digit == 2'd1) begin
                pos_q <= sat_inc(pos_q);
            end else if (digit == 2'd2) begin
                neg_q <= sat_inc(neg_q);
            end else begin
                zero_q <= sat_inc(zero_q);
            end
        end
    end

    assign stat_pos_o  = pos_q;
    assign stat_neg_o  = neg_q;
    assign stat_zero_o = zero_q;
`endif
endmodule
